// File: rtl/bcd_subtractor_serial.sv
// bcd_subtractor_serial: digit-serial packed-BCD A-B via ten's complement, LSD first
//   clk, rst_n (sync, active-low), start -> accept A,B (4*DIGITS packed BCD) when idle
//   busy while digits are processed, done one-cycle pulse; D magnitude, Neg (A<B), Invalid (digit>9)
module bcd_subtractor_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] D,
  output logic                Neg,
  output logic                Invalid
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS) + 1;
  typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, r_q, r_d, d_q, d_d;
  logic [IW-1:0] i_q, i_d;
  logic c_q, c_d, neg_q, neg_d, inv_q, inv_d;
  logic bad, last, sub_c, fix_c;
  logic [4:0] s, t;
  logic [3:0] sub_r, fix_r;
  always_comb begin
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++)
      bad = bad | (A[4*k +: 4] > 4'd9) | (B[4*k +: 4] > 4'd9);
  end
  // operands and working result shift right one digit per step, so digit 0 is always the live one
  // and each new result digit enters at the top
  always_comb begin
    s     = {1'b0, a_q[3:0]} + 5'd9 - {1'b0, b_q[3:0]} + {4'b0, c_q};
    sub_c = s >= 5'd10;
    sub_r = sub_c ? 4'(s - 5'd10) : s[3:0];
    t     = 5'd9 - {1'b0, r_q[3:0]} + {4'b0, c_q};
    fix_c = t == 5'd10;
    fix_r = fix_c ? 4'd0 : t[3:0];
    last  = i_q == IW'(DIGITS - 1);
  end
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    d_d = d_q;
    i_d = i_q;
    c_d = c_q;
    neg_d = neg_q;
    inv_d = inv_q;
    case (state_q)
      IDLE: if (start) begin
        a_d = A;
        b_d = B;
        r_d = '0;
        i_d = '0;
        c_d = 1'b1;
        state_d = bad ? DONE : SUB;
        if (bad) begin
          d_d = '0;
          neg_d = 1'b0;
          inv_d = 1'b1;
        end
      end
      SUB: begin
        a_d = a_q >> 4;
        b_d = b_q >> 4;
        r_d = (r_q >> 4) | (W'(sub_r) << (W - 4));
        c_d = sub_c;
        i_d = i_q + 1'b1;
        if (last) begin
          i_d = '0;
          c_d = 1'b1;
          state_d = sub_c ? DONE : FIX;
          if (sub_c) begin
            d_d = r_d;
            neg_d = 1'b0;
            inv_d = 1'b0;
          end
        end
      end
      FIX: begin
        r_d = (r_q >> 4) | (W'(fix_r) << (W - 4));
        c_d = fix_c;
        i_d = i_q + 1'b1;
        if (last) begin
          state_d = DONE;
          d_d = r_d;
          neg_d = 1'b1;
          inv_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      d_q <= '0;
      i_q <= '0;
      c_q <= 1'b0;
      neg_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      d_q <= d_d;
      i_q <= i_d;
      c_q <= c_d;
      neg_q <= neg_d;
      inv_q <= inv_d;
    end
  end
  assign busy = state_q == SUB || state_q == FIX;
  assign done = state_q == DONE;
  assign D = d_q;
  assign Neg = neg_q;
  assign Invalid = inv_q;
endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// tb_bcd_subtractor_serial: directed self-checking bench for the 4-digit serial BCD subtractor
module tb_bcd_subtractor_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] D;
  logic busy, done, Neg, Invalid;
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] last_d = '0;
  bcd_subtractor_serial #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .D(D), .Neg(Neg), .Invalid(Invalid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b, input int lat,
                    input logic [15:0] ed, input logic en, input logic ei, input logic inject);
    int n = 0;
    int bz = 0;
    logic held = 1'b1;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (inject && n == 3) begin
        A = 16'h9000;
        B = 16'h0001;
        start = 1'b1;
      end
      if (busy) bz++;
      if (!done && D !== last_d) held = 1'b0;
    end while (!done && n < 40);
    start = 1'b0;
    check({tag, "_lat"}, n, lat);
    check({tag, "_busy"}, bz, lat - 1);
    check({tag, "_D"}, D, ed);
    check({tag, "_neg"}, Neg, en);
    check({tag, "_inv"}, Invalid, ei);
    check({tag, "_hold"}, held, 1'b1);
    @(negedge clk);
    check({tag, "_pulse"}, done, 1'b0);
    last_d = ed;
  endtask
  initial begin
    logic saw;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_D", D, 16'h0000);
    check("rst_neg", Neg, 1'b0);
    check("rst_inv", Invalid, 1'b0);
    rst_n = 1'b1;
    op("pos", 16'h1234, 16'h0567, 5, 16'h0667, 1'b0, 1'b0, 1'b0);
    op("neg", 16'h0567, 16'h1234, 9, 16'h0667, 1'b1, 1'b0, 1'b0);
    op("eq", 16'h0500, 16'h0500, 5, 16'h0000, 1'b0, 1'b0, 1'b0);
    op("zmax", 16'h0000, 16'h9999, 9, 16'h9999, 1'b1, 1'b0, 1'b0);
    op("maxz", 16'h9999, 16'h0000, 5, 16'h9999, 1'b0, 1'b0, 1'b0);
    op("bad", 16'h12A4, 16'h0001, 1, 16'h0000, 1'b0, 1'b1, 1'b0);
    op("after", 16'h0003, 16'h0001, 5, 16'h0002, 1'b0, 1'b0, 1'b0);
    op("ign", 16'h0100, 16'h0200, 9, 16'h0100, 1'b1, 1'b0, 1'b1);
    op("borrow", 16'h1000, 16'h0001, 5, 16'h0999, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    A = 16'h0001;
    B = 16'h0002;
    start = 1'b1;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_busy", busy, 1'b0);
    check("mid_D", D, 16'h0000);
    check("mid_neg", Neg, 1'b0);
    saw = done;
    repeat (12) begin
      @(negedge clk);
      saw = saw | done;
    end
    check("mid_nodone", saw, 1'b0);
    last_d = '0;
    op("post", 16'h0003, 16'h0001, 5, 16'h0002, 1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
